// File: rtl/spi_master_mc.sv
// SPI master: full-duplex DATA_W-bit transfers, runtime CPOL/CPHA, fixed SCK divider,
// and command-driven one-hot chip selects.
module spi_master_mc #(
    parameter int DATA_W   = 8,
    parameter int DIV      = 2,
    parameter int NUM_CS   = 2,
    parameter int CS_SEL_W = 1
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          cmd,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   tx_dat,
    input  logic                miso,
    output logic                mosi,
    output logic                sck,
    output logic [NUM_CS-1:0]   cs_n,
    output logic [DATA_W-1:0]   rx_dat,
    output logic                done,
    output logic                busy
);

    localparam int HP_W = $clog2(DIV) + 1;
    localparam int EC_W = $clog2(2 * DATA_W + 1);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(DIV - 1);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_W - 1);

    localparam logic [1:0] CMD_XFER    = 2'b00;
    localparam logic [1:0] CMD_ASSERT  = 2'b01;
    localparam logic [1:0] CMD_RELEASE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CSOP  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [HP_W-1:0]   hp_cnt_reg;
    logic [EC_W-1:0]   edge_cnt_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_dat_reg;
    logic [NUM_CS-1:0] cs_n_reg;
    logic              cpha_reg;
    logic              sck_reg;
    logic              mosi_reg;
    logic              done_reg;

    logic              accept;
    logic              hp_wrap;
    logic              leading;
    logic              sample_edge;
    logic              last_edge;
    logic [NUM_CS-1:0] cs_dec;

    // Out-of-range cs_sel matches no output, leaving every select high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign cs_dec[gi] = (cs_sel != CS_SEL_W'(gi));
        end
    endgenerate

    assign accept      = start && (state_reg == IDLE);
    assign hp_wrap     = (hp_cnt_reg == HP_LAST);
    // Edge number n = edge_cnt_reg + 1, so odd n (leading) means an even count.
    assign leading     = ~edge_cnt_reg[0];
    assign sample_edge = leading ^ cpha_reg;
    assign last_edge   = (state_reg == SHIFT) && hp_wrap && (edge_cnt_reg == EC_LAST);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (cmd == CMD_XFER) ? SHIFT : CSOP;
                end
            end
            SHIFT: begin
                if (last_edge) begin
                    state_next = IDLE;
                end
            end
            CSOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hp_cnt_reg   <= '0;
            edge_cnt_reg <= '0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_dat_reg   <= '0;
            cs_n_reg     <= '1;
            cpha_reg     <= 1'b0;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                cpha_reg     <= cpha;
                sck_reg      <= cpol;
                hp_cnt_reg   <= '0;
                edge_cnt_reg <= '0;
                case (cmd)
                    CMD_XFER: begin
                        // With cpha=0 the MSB is presented immediately; otherwise on the first leading edge.
                        if (cpha) begin
                            tx_sh_reg <= tx_dat;
                        end else begin
                            mosi_reg  <= tx_dat[DATA_W-1];
                            tx_sh_reg <= {tx_dat[DATA_W-2:0], 1'b0};
                        end
                    end
                    CMD_ASSERT:  cs_n_reg <= cs_dec;
                    CMD_RELEASE: cs_n_reg <= '1;
                    default: ;
                endcase
            end else if (state_reg == CSOP) begin
                done_reg <= 1'b1;
            end else if (state_reg == SHIFT) begin
                if (hp_wrap) begin
                    hp_cnt_reg   <= '0;
                    edge_cnt_reg <= edge_cnt_reg + EC_W'(1);
                    sck_reg      <= ~sck_reg;
                    if (sample_edge) begin
                        rx_sh_reg <= {rx_sh_reg[DATA_W-2:0], miso};
                    end else if (!last_edge) begin
                        mosi_reg  <= tx_sh_reg[DATA_W-1];
                        tx_sh_reg <= {tx_sh_reg[DATA_W-2:0], 1'b0};
                    end
                    if (last_edge) begin
                        done_reg   <= 1'b1;
                        // In cpha=1 the final sample lands on this same edge.
                        rx_dat_reg <= cpha_reg ? {rx_sh_reg[DATA_W-2:0], miso} : rx_sh_reg;
                    end
                end else begin
                    hp_cnt_reg <= hp_cnt_reg + HP_W'(1);
                end
            end
        end
    end

    assign mosi   = mosi_reg;
    assign sck    = sck_reg;
    assign cs_n   = cs_n_reg;
    assign rx_dat = rx_dat_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: an 8-bit/DIV=2 instance against a bit-indexed SPI slave model,
// plus a 16-bit/DIV=1 loopback instance.
module tb_spi_master_mc;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst;

    logic       start_a, cpol_a, cpha_a, miso_a, mosi_a, sck_a, done_a, busy_a;
    logic [1:0] cmd_a, cs_sel_a, cs_n_a;
    logic [7:0] tx_a, rx_a;

    spi_master_mc #(.DATA_W(8), .DIV(2), .NUM_CS(2), .CS_SEL_W(2)) u_a (
        .sys_clk(sys_clk), .rst(rst), .start(start_a), .cmd(cmd_a), .cpol(cpol_a),
        .cpha(cpha_a), .cs_sel(cs_sel_a), .tx_dat(tx_a), .miso(miso_a), .mosi(mosi_a),
        .sck(sck_a), .cs_n(cs_n_a), .rx_dat(rx_a), .done(done_a), .busy(busy_a)
    );

    logic        start_b, cpol_b, cpha_b, mosi_b, sck_b, done_b, busy_b;
    logic [1:0]  cmd_b, cs_n_b;
    logic [0:0]  cs_sel_b;
    logic [15:0] tx_b, rx_b;

    spi_master_mc #(.DATA_W(16), .DIV(1), .NUM_CS(2), .CS_SEL_W(1)) u_b (
        .sys_clk(sys_clk), .rst(rst), .start(start_b), .cmd(cmd_b), .cpol(cpol_b),
        .cpha(cpha_b), .cs_sel(cs_sel_b), .tx_dat(tx_b), .miso(mosi_b), .mosi(mosi_b),
        .sck(sck_b), .cs_n(cs_n_b), .rx_dat(rx_b), .done(done_b), .busy(busy_b)
    );

    int nvec = 0;
    int nerr = 0;

    // Slave model state: the slave presents bit number idx (0 = MSB) of slave_word.
    logic       m_cpol = 1'b0, m_cpha = 1'b0, loop_en = 1'b0, mon_en = 1'b0;
    logic [7:0] slave_word = 8'h00, slave_cap = 8'h00;
    logic       sck_prev = 1'b0, slave_bit;
    int         sh_cnt = 0, edges = 0, idx;
    logic [1:0] cs_exp = 2'b11;
    logic [7:0] rx_prev = 8'h00;

    always_comb begin
        idx       = m_cpha ? sh_cnt - 1 : sh_cnt;
        slave_bit = 1'b0;
        if (idx >= 0 && idx < 8) slave_bit = slave_word[7 - idx];
        miso_a = loop_en ? mosi_a : slave_bit;
    end

    // Observe sck just after each rising sys_clk edge; leading = leaving the idle level.
    always @(posedge sys_clk) begin
        #1;
        if (!mon_en) begin
            sh_cnt    = 0;
            edges     = 0;
            slave_cap = 8'h00;
        end else if (sck_a !== sck_prev) begin
            edges = edges + 1;
            if ((sck_prev == m_cpol) == m_cpha) sh_cnt = sh_cnt + 1;
            else slave_cap = {slave_cap[6:0], mosi_a};
        end
        sck_prev = sck_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_xfer(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] sw,
                              input logic lp, input logic hold);
        @(negedge sys_clk);
        m_cpol = mode[1]; m_cpha = mode[0]; slave_word = sw; loop_en = lp;
        start_a = 1'b1; cmd_a = 2'b00; cpol_a = mode[1]; cpha_a = mode[0]; tx_a = tx;
        @(posedge sys_clk);
        @(negedge sys_clk);
        if (!hold) start_a = 1'b0;
        check("busy_after_accept", busy_a, 1);
        check("sck_after_accept", sck_a, mode[1]);
        if (!mode[0]) check("mosi_msb_at_accept", mosi_a, tx[7]);
        mon_en = 1'b1;
    endtask

    task automatic wait_xfer(input logic [7:0] exp_rx, input logic [7:0] exp_cap);
        int cyc = 0;
        int bad = 0;
        while (done_a !== 1'b1 && cyc < 200) begin
            if (rx_a !== rx_prev || busy_a !== 1'b1) bad++;
            @(negedge sys_clk);
            cyc++;
        end
        $display("xfer: mode=%0d%0d rx=%02h exp=%02h cap=%02h edges=%0d cycles=%0d",
                 m_cpol, m_cpha, rx_a, exp_rx, slave_cap, edges, cyc);
        check("busy_rx_hold_during_xfer", bad, 0);
        check("done_latency", cyc, 32);
        check("rx_dat", rx_a, exp_rx);
        check("busy_at_done", busy_a, 0);
        check("sck_edges", edges, 16);
        check("slave_rx_mosi", slave_cap, exp_cap);
        check("sck_idle", sck_a, m_cpol);
        check("cs_untouched", cs_n_a, cs_exp);
        rx_prev = exp_rx;
        mon_en  = 1'b0;
    endtask

    task automatic cs_cmd(input logic [1:0] c, input logic [1:0] sel, input logic [1:0] exp_cs);
        @(negedge sys_clk);
        start_a = 1'b1; cmd_a = c; cs_sel_a = sel; cpol_a = 1'b0; cpha_a = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        start_a = 1'b0;
        $display("cs_cmd: cmd=%0d sel=%0d cs_n=%02b exp=%02b", c, sel, cs_n_a, exp_cs);
        check("cs_n_at_accept", cs_n_a, exp_cs);
        check("cs_busy", busy_a, 1);
        check("cs_done_early", done_a, 0);
        @(negedge sys_clk);
        check("cs_done", done_a, 1);
        check("cs_busy_clear", busy_a, 0);
        check("cs_n_hold", cs_n_a, exp_cs);
        check("cs_sck_idle", sck_a, 0);
        @(negedge sys_clk);
        check("cs_done_pulse", done_a, 0);
        cs_exp = exp_cs;
    endtask

    task automatic xfer_b(input logic [15:0] tx);
        int cyc = 0;
        @(negedge sys_clk);
        start_b = 1'b1; cmd_b = 2'b00; cpol_b = 1'b0; cpha_b = 1'b1; tx_b = tx;
        @(posedge sys_clk);
        @(negedge sys_clk);
        start_b = 1'b0;
        while (done_b !== 1'b1 && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
        $display("xfer_b: tx=%04h rx=%04h cycles=%0d", tx, rx_b, cyc);
        check("b_done_latency", cyc, 32);
        check("b_rx_dat", rx_b, tx);
    endtask

    initial begin
        logic [7:0] tx, sw;
        logic [1:0] mode;
        logic       lp;
        int         t;
        int         ndone;

        rst = 1'b1;
        start_a = 0; cmd_a = 2'b11; cpol_a = 0; cpha_a = 0; cs_sel_a = 0; tx_a = 0;
        start_b = 0; cmd_b = 2'b11; cpol_b = 0; cpha_b = 0; cs_sel_b = 0; tx_b = 0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        $display("reset: mosi=%0b sck=%0b cs_n=%02b rx=%02h done=%0b busy=%0b",
                 mosi_a, sck_a, cs_n_a, rx_a, done_a, busy_a);
        check("rst_mosi", mosi_a, 0);
        check("rst_sck", sck_a, 0);
        check("rst_cs_n", cs_n_a, 2'b11);
        check("rst_rx_dat", rx_a, 0);
        check("rst_done", done_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_rx_dat", rx_b, 0);

        cs_cmd(2'b01, 2'd0, 2'b10);

        begin_xfer(2'b00, 8'hA5, 8'h00, 1'b1, 1'b0);
        wait_xfer(8'hA5, 8'hA5);
        @(negedge sys_clk);
        check("xfer_done_pulse", done_a, 0);

        begin_xfer(2'b11, 8'h81, 8'h3C, 1'b0, 1'b0);
        wait_xfer(8'h3C, 8'h81);

        for (int i = 0; i < 6; i++) begin
            mode = 2'($urandom_range(0, 3));
            tx   = 8'($urandom);
            sw   = 8'($urandom);
            lp   = 1'($urandom_range(0, 1));
            begin_xfer(mode, tx, sw, lp, 1'b0);
            wait_xfer(lp ? tx : sw, tx);
        end

        // start held high: the second word goes in only right after the done cycle.
        begin_xfer(2'b00, 8'hFF, 8'h00, 1'b1, 1'b1);
        wait_xfer(8'hFF, 8'hFF);
        tx_a = 8'h5A;
        @(posedge sys_clk);
        @(negedge sys_clk);
        start_a = 1'b0;
        check("reaccept_after_done", busy_a, 1);
        check("first_rx_kept", rx_a, 8'hFF);
        mon_en = 1'b1;
        wait_xfer(8'h5A, 8'h5A);

        cs_cmd(2'b01, 2'd1, 2'b01);
        cs_cmd(2'b01, 2'd3, 2'b11);
        cs_cmd(2'b01, 2'd0, 2'b10);
        cs_cmd(2'b11, 2'd1, 2'b10);
        cs_cmd(2'b10, 2'd0, 2'b11);
        cs_cmd(2'b01, 2'd0, 2'b10);

        // Reset after the seventh sck edge of a transfer.
        begin_xfer(2'b00, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        t = 0;
        while (edges < 7 && t < 100) begin
            @(negedge sys_clk);
            t++;
        end
        check("edge7_reached", edges, 7);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        mon_en = 1'b0;
        $display("mid_rst: sck=%0b cs_n=%02b busy=%0b rx=%02h done=%0b",
                 sck_a, cs_n_a, busy_a, rx_a, done_a);
        check("midrst_sck", sck_a, 0);
        check("midrst_cs_n", cs_n_a, 2'b11);
        check("midrst_busy", busy_a, 0);
        check("midrst_rx_dat", rx_a, 0);
        check("midrst_mosi", mosi_a, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_a !== 1'b0) ndone++;
            @(negedge sys_clk);
        end
        check("midrst_no_done", ndone, 0);
        cs_exp  = 2'b11;
        rx_prev = 8'h00;

        xfer_b(16'h1234);
        for (int i = 0; i < 3; i++) xfer_b(16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
